// File: rtl/tqvp_neuro_spike_encoder.sv
// Spike encoder peripheral: queued {direction, count} commands are played out
// as pulse trains on one of four spike lines with programmable high/gap widths.
// Optional build macro SPIKE_ENC_TOTAL_EN adds the TOTAL spike counter at 0x0C.
module tqvp_neuro_spike_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  state_t           state_q, state_d;
  logic [7:0]       phase_q, phase_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [3:0]       spike_q, spike_d;

  logic             en_q, irq_en_q, en_d, irq_en_d;
  logic [7:0]       h_q, g_q, h_d, g_d;
  logic             done_q, ovf_q, irq_q;
  logic             done_d, ovf_d, irq_d;

  logic [1:0]       fifo_dir_q [FIFO_DEPTH];
  logic [CNT_W-1:0] fifo_cnt_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0] level_q;

  logic             wr_en, wr_cmd, wr_ctrl, wr_clear, clr_flags;
  logic [CNT_W-1:0] cmd_count;
  logic             push_req, push, pop;
  logic             fifo_empty, fifo_full;
  logic             spike_inc, done_set, ovf_set;
  logic [7:0]       h_load, g_load;
  logic [31:0]      total_rd;
  logic             pause;

  assign pause      = ui_in[0];
  assign wr_en      = (data_write_n != 2'b11);
  assign wr_cmd     = wr_en && (address == 6'h00);
  assign wr_ctrl    = wr_en && (address == 6'h04);
  assign wr_clear   = wr_en && (address == 6'h10);
  assign clr_flags  = wr_clear && data_in[0];
  assign cmd_count  = data_in[16 +: CNT_W];

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign push_req   = wr_cmd && (cmd_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;

  assign h_load = (h_q == 8'd0) ? 8'd0 : h_q - 8'd1;
  assign g_load = (g_q == 8'd0) ? 8'd0 : g_q - 8'd1;

  // Next-state logic for the pulse sequencer: IDLE -> HIGH -> LOW -> ...
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    pop       = 1'b0;
    spike_inc = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && !fifo_empty) begin
          pop     = 1'b1;
          dir_d   = fifo_dir_q[rd_ptr_q];
          rem_d   = fifo_cnt_q[rd_ptr_q];
          phase_d = h_load;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_q == 8'd0) begin
          rem_d     = rem_q - CNT_W'(1);
          spike_inc = 1'b1;
          phase_d   = g_load;
          state_d   = ST_LOW;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ST_LOW: begin
        if (phase_q != 8'd0) begin
          phase_d = phase_q - 8'd1;
        end else if (!pause) begin
          if (rem_q != '0 && en_q) begin
            phase_d = h_load;
            state_d = ST_HIGH;
          end else if (rem_q == '0 && en_q && !fifo_empty) begin
            pop     = 1'b1;
            dir_d   = fifo_dir_q[rd_ptr_q];
            rem_d   = fifo_cnt_q[rd_ptr_q];
            phase_d = h_load;
            state_d = ST_HIGH;
          end else begin
            done_set = (rem_q == '0);
            rem_d    = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Spike lines follow the next state so a pulse starts on the pop edge.
  always_comb begin
    spike_d = '0;
    if (state_d == ST_HIGH) spike_d = 4'b0001 << dir_d;
  end

  // Sequencer state and registered spike outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      dir_q   <= '0;
      rem_q   <= '0;
      spike_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      spike_q <= spike_d;
    end
  end

  // CTRL register fields.
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    h_d      = h_q;
    g_d      = g_q;
    if (wr_ctrl) begin
      en_d     = data_in[0];
      irq_en_d = data_in[1];
      h_d      = data_in[15:8];
      g_d      = data_in[23:16];
    end
  end

  // Sticky flags: a set event in the same cycle as a CLEAR wins.
  always_comb begin
    done_d = done_set | (done_q & ~clr_flags);
    ovf_d  = ovf_set  | (ovf_q  & ~clr_flags);
    irq_d  = irq_en_d & (done_d | ovf_d);
  end

  // Control, flag and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      h_q      <= '0;
      g_q      <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      h_q      <= h_d;
      g_q      <= g_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Command FIFO pointers and fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Command FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dir_q[wr_ptr_q] <= data_in[1:0];
      fifo_cnt_q[wr_ptr_q] <= cmd_count;
    end
  end

`ifdef SPIKE_ENC_TOTAL_EN
  logic [31:0] total_q, total_d;
  logic        wr_total;
  assign wr_total = wr_en && (address == 6'h0C);

  // Clearing takes priority over a coincident increment.
  always_comb begin
    total_d = total_q + 32'(spike_inc);
    if (wr_total) total_d = '0;
  end

  // Running count of emitted spikes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end
  assign total_rd = total_q;
`else
  logic unused_spike_inc;
  assign unused_spike_inc = spike_inc;
  assign total_rd = '0;
`endif

  // Combinational register readback; reads have no side effects.
  always_comb begin
    data_out = '0;
    case (address)
      6'h04:   data_out = {8'h00, g_q, h_q, 6'h00, irq_en_q, en_q};
      6'h08:   data_out = {16'(rem_q), 9'h000, done_q, ovf_q,
                           (state_q != ST_IDLE), 4'(level_q)};
      6'h0C:   data_out = total_rd;
      default: data_out = '0;
    endcase
  end

  assign uo_out         = {2'b00, fifo_full, (state_q != ST_IDLE), spike_q};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, data_read_n, ui_in[7:1], data_in};

endmodule
